// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlul_pkg
// Description : TL-UL opcode encodings and width helpers shared by the
//               outstanding master slice.
// Revision    : 1.0 - initial release
// ============================================================================
package tlul_pkg;

    localparam logic [2:0] c_A_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] c_A_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] c_A_GET              = 3'd4;
    localparam logic [2:0] c_D_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] c_D_ACCESS_ACK_DATA  = 3'd1;

    typedef enum logic [2:0] {
        A_PUT_FULL_DATA    = c_A_PUT_FULL_DATA,
        A_PUT_PARTIAL_DATA = c_A_PUT_PARTIAL_DATA,
        A_GET              = c_A_GET
    } tl_a_opcode_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = c_D_ACCESS_ACK,
        D_ACCESS_ACK_DATA = c_D_ACCESS_ACK_DATA
    } tl_d_opcode_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int tag_width(input int slots);
        return (clog2(slots) < 1) ? 1 : clog2(slots);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlul_outstanding_master_if.sv
`default_nettype none
// ============================================================================
// Module      : tlul_outstanding_master_if
// Description : User request/response and TL-UL A/D channel bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlul_outstanding_master_if #(
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_ADDR_WIDTH   = 32,
    parameter int TL_SOURCE_WIDTH = 8,
    parameter int MAX_OUTSTANDING = 4
);
    import tlul_pkg::*;

    localparam int TAGW = tag_width(MAX_OUTSTANDING);
    localparam int BW   = TL_DATA_WIDTH / 8;

    logic                       i_req_valid;
    logic                       o_req_ready;
    logic                       i_req_write;
    logic [TL_ADDR_WIDTH-1:0]   i_req_addr;
    logic [TL_DATA_WIDTH-1:0]   i_req_wdata;
    logic [BW-1:0]              i_req_mask;
    logic [TAGW-1:0]            o_req_tag;

    logic                       o_rsp_valid;
    logic                       i_rsp_ready;
    logic [TL_DATA_WIDTH-1:0]   o_rsp_rdata;
    logic [TAGW-1:0]            o_rsp_tag;
    logic                       o_rsp_write;
    logic                       o_rsp_error;

    logic                       o_busy;
    logic [TAGW:0]              o_outstanding;

    logic                       o_a_valid;
    logic                       i_a_ready;
    logic [2:0]                 o_a_opcode;
    logic [2:0]                 o_a_param;
    logic [3:0]                 o_a_size;
    logic [TL_SOURCE_WIDTH-1:0] o_a_source;
    logic [TL_ADDR_WIDTH-1:0]   o_a_address;
    logic [BW-1:0]              o_a_mask;
    logic [TL_DATA_WIDTH-1:0]   o_a_data;

    logic                       i_d_valid;
    logic                       o_d_ready;
    logic [2:0]                 i_d_opcode;
    logic [TL_SOURCE_WIDTH-1:0] i_d_source;
    logic                       i_d_denied;
    logic                       i_d_corrupt;
    logic [TL_DATA_WIDTH-1:0]   i_d_data;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_mask,
        output o_req_ready, o_req_tag,
        input  i_rsp_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_tag, o_rsp_write, o_rsp_error,
        output o_busy, o_outstanding,
        input  i_a_ready,
        output o_a_valid, o_a_opcode, o_a_param, o_a_size, o_a_source,
               o_a_address, o_a_mask, o_a_data,
        input  i_d_valid, i_d_opcode, i_d_source, i_d_denied, i_d_corrupt, i_d_data,
        output o_d_ready
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_mask,
        input  o_req_ready, o_req_tag,
        output i_rsp_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_tag, o_rsp_write, o_rsp_error,
        input  o_busy, o_outstanding,
        output i_a_ready,
        input  o_a_valid, o_a_opcode, o_a_param, o_a_size, o_a_source,
               o_a_address, o_a_mask, o_a_data,
        output i_d_valid, i_d_opcode, i_d_source, i_d_denied, i_d_corrupt, i_d_data,
        input  o_d_ready
    );

endinterface
`default_nettype wire

// File: rtl/tlul_source_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tlul_source_alloc
// Description : Free bitmap with per-slot write flag, lowest-free priority
//               encoder and population count.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_source_alloc #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAGW            = 2
) (
    input  wire logic                       i_clk,
    input  wire logic                       i_reset,
    input  wire logic                       i_alloc,
    input  wire logic                       i_alloc_write,
    output logic                            o_free_any,
    output logic [TAGW-1:0]                 o_free_idx,
    input  wire logic                       i_free,
    input  wire logic [TAGW-1:0]            i_free_idx,
    output logic [MAX_OUTSTANDING-1:0]      o_slot_busy,
    output logic [MAX_OUTSTANDING-1:0]      o_slot_write,
    output logic [TAGW:0]                   o_count
);

    logic [MAX_OUTSTANDING-1:0] r_busy;
    logic [MAX_OUTSTANDING-1:0] r_write;

    // Alloc always targets a free slot and free a busy one, so both apply.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy  <= '0;
            r_write <= '0;
        end else begin
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                if (i_free && (i_free_idx == TAGW'(k))) begin
                    r_busy[k] <= 1'b0;
                end
                if (i_alloc && (o_free_idx == TAGW'(k))) begin
                    r_busy[k]  <= 1'b1;
                    r_write[k] <= i_alloc_write;
                end
            end
        end
    end

    always_comb begin
        o_free_any = 1'b0;
        o_free_idx = '0;
        for (int k = MAX_OUTSTANDING - 1; k >= 0; k--) begin
            if (!r_busy[k]) begin
                o_free_any = 1'b1;
                o_free_idx = TAGW'(k);
            end
        end
    end

    always_comb begin
        o_count = '0;
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            o_count = o_count + (TAGW + 1)'(r_busy[k]);
        end
    end

    assign o_slot_busy  = r_busy;
    assign o_slot_write = r_write;

endmodule
`default_nettype wire

// File: rtl/tlul_outstanding_master.sv
`default_nettype none
// ============================================================================
// Module      : tlul_outstanding_master
// Description : TL-UL master with MAX_OUTSTANDING in-flight transactions and
//               out-of-order responses. Option: TLUL_MASTER_PARTIAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_outstanding_master
    import tlul_pkg::*;
#(
    parameter int TL_DATA_WIDTH   = 64,
    parameter int TL_ADDR_WIDTH   = 32,
    parameter int TL_SOURCE_WIDTH = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SOURCE_BASE     = 'h0A
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    tlul_outstanding_master_if.master  bus
);

    localparam int TAGW = tag_width(MAX_OUTSTANDING);
    localparam int BW   = TL_DATA_WIDTH / 8;
    localparam int OFFW = clog2(BW);
    localparam logic [BW-1:0]              c_FULL_MASK   = {BW{1'b1}};
    localparam logic [TL_SOURCE_WIDTH-1:0] c_SOURCE_BASE = TL_SOURCE_WIDTH'(SOURCE_BASE);
    localparam logic [TL_ADDR_WIDTH-1:0]   c_ADDR_MASK   = ~(TL_ADDR_WIDTH'((1 << OFFW) - 1));

    logic                       w_free_any;
    logic [TAGW-1:0]            w_free_idx;
    logic [MAX_OUTSTANDING-1:0] w_slot_busy;
    logic [MAX_OUTSTANDING-1:0] w_slot_write;
    logic [TAGW:0]              w_count;

    logic                       w_req_ready;
    logic                       w_req_fire;
    logic [BW-1:0]              w_put_mask;
    tl_a_opcode_e               w_put_opcode;

    logic                       r_a_valid;
    tl_a_opcode_e               r_a_opcode;
    logic [TL_SOURCE_WIDTH-1:0] r_a_source;
    logic [TL_ADDR_WIDTH-1:0]   r_a_address;
    logic [BW-1:0]              r_a_mask;
    logic [TL_DATA_WIDTH-1:0]   r_a_data;

    logic                       w_d_ready;
    logic                       w_d_fire;
    logic [TL_SOURCE_WIDTH-1:0] w_d_idx;
    logic [TAGW-1:0]            w_d_tag;
    logic                       w_known;
    logic                       w_known_write;
    logic                       w_op_mismatch;
    logic                       w_d_error;
    logic [TL_DATA_WIDTH-1:0]   w_d_rdata;

    logic                       r_rsp_valid;
    logic [TL_DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [TAGW-1:0]            r_rsp_tag;
    logic                       r_rsp_write;
    logic                       r_rsp_error;

`ifdef TLUL_MASTER_PARTIAL_EN
    assign w_put_mask = bus.i_req_mask;
`else
    logic w_unused_mask;
    assign w_unused_mask = ^bus.i_req_mask;
    assign w_put_mask    = c_FULL_MASK;
`endif
    assign w_put_opcode = (w_put_mask == c_FULL_MASK) ? A_PUT_FULL_DATA : A_PUT_PARTIAL_DATA;

    assign w_req_ready = !i_reset && w_free_any && (!r_a_valid || bus.i_a_ready);
    assign w_req_fire  = bus.i_req_valid && w_req_ready;

    assign w_d_ready = !r_rsp_valid || bus.i_rsp_ready;
    assign w_d_fire  = bus.i_d_valid && w_d_ready;
    assign w_d_idx   = bus.i_d_source - c_SOURCE_BASE;
    assign w_d_tag   = w_d_idx[TAGW-1:0];

    tlul_source_alloc #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TAGW            (TAGW)
    ) u_alloc (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_alloc       (w_req_fire),
        .i_alloc_write (bus.i_req_write),
        .o_free_any    (w_free_any),
        .o_free_idx    (w_free_idx),
        .i_free        (w_d_fire && w_known),
        .i_free_idx    (w_d_tag),
        .o_slot_busy   (w_slot_busy),
        .o_slot_write  (w_slot_write),
        .o_count       (w_count)
    );

    // Only a source that maps onto a currently busy slot counts as known.
    always_comb begin
        w_known       = 1'b0;
        w_known_write = 1'b0;
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            if ((w_d_idx == TL_SOURCE_WIDTH'(k)) && w_slot_busy[k]) begin
                w_known       = 1'b1;
                w_known_write = w_slot_write[k];
            end
        end
    end

    assign w_op_mismatch = w_known_write ? (bus.i_d_opcode != D_ACCESS_ACK)
                                         : (bus.i_d_opcode != D_ACCESS_ACK_DATA);
    assign w_d_error = !w_known || bus.i_d_denied ||
                       (bus.i_d_corrupt && !w_known_write) || w_op_mismatch;
    assign w_d_rdata = (w_known && !w_known_write && !w_d_error) ? bus.i_d_data : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a_valid   <= 1'b0;
            r_a_opcode  <= A_PUT_FULL_DATA;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
        end else if (w_req_fire) begin
            r_a_valid   <= 1'b1;
            r_a_opcode  <= bus.i_req_write ? w_put_opcode : A_GET;
            r_a_source  <= c_SOURCE_BASE + TL_SOURCE_WIDTH'(w_free_idx);
            r_a_address <= bus.i_req_addr & c_ADDR_MASK;
            r_a_mask    <= bus.i_req_write ? w_put_mask : c_FULL_MASK;
            r_a_data    <= bus.i_req_write ? bus.i_req_wdata : '0;
        end else if (bus.i_a_ready) begin
            r_a_valid   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_tag   <= '0;
            r_rsp_write <= 1'b0;
            r_rsp_error <= 1'b0;
        end else if (w_d_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_d_rdata;
            r_rsp_tag   <= w_d_tag;
            r_rsp_write <= w_known_write;
            r_rsp_error <= w_d_error;
        end else if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.o_req_ready   = w_req_ready;
    assign bus.o_req_tag     = w_free_idx;
    assign bus.o_rsp_valid   = r_rsp_valid;
    assign bus.o_rsp_rdata   = r_rsp_rdata;
    assign bus.o_rsp_tag     = r_rsp_tag;
    assign bus.o_rsp_write   = r_rsp_write;
    assign bus.o_rsp_error   = r_rsp_error;
    assign bus.o_busy        = (|w_slot_busy) || r_a_valid;
    assign bus.o_outstanding = w_count;
    assign bus.o_a_valid     = r_a_valid;
    assign bus.o_a_opcode    = r_a_opcode;
    assign bus.o_a_param     = 3'd0;
    assign bus.o_a_size      = 4'(OFFW);
    assign bus.o_a_source    = r_a_source;
    assign bus.o_a_address   = r_a_address;
    assign bus.o_a_mask      = r_a_mask;
    assign bus.o_a_data      = r_a_data;
    assign bus.o_d_ready     = w_d_ready;

endmodule
`default_nettype wire
